// File: rtl/iob_sp_ram_arb_pkg.sv
// Shared definitions for the two-port round-robin RAM arbiter: port-select
// encoding, default bus widths, the pending-read record and the grant pick.
package iob_sp_ram_arb_pkg;

    // Default geometry: 1024 words of 32 bits.
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 10;

    // Port-select encoding, used for grants, last_grant and pending reads.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Outstanding read: returns data to 'port' in the cycle after its grant.
    typedef struct packed {
        logic valid;
        logic port;
    } pend_t;

    // Round-robin pick among the valid requesters.
    // With both valid, the port that did not win last time is chosen.
    // With neither valid the result is unused by the caller.
    function automatic logic rr_pick(
        input logic a_v,
        input logic b_v,
        input logic last_grant
    );
        logic pick;
        if (a_v && b_v) begin
            pick = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (a_v) begin
            pick = PORT_A;
        end else begin
            pick = PORT_B;
        end
        return pick;
    endfunction

endpackage

// File: rtl/iob_sp_ram.sv
// Single-port synchronous RAM: one access per cycle when en is high.
// Writes store din; reads update dout on the clock edge, so read data is
// available one cycle after the access. dout holds between reads.
module iob_sp_ram
    import iob_sp_ram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;

    // Storage array and registered read port.
    // NOTE: the array has no reset so it maps onto RAM macros; contents
    // survive the arbiter's reset. Non-blocking updates keep the read of
    // the old word and the write of a new one race-free on the same edge.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= din;
            end else begin
                r_dout <= r_mem[addr];
            end
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/iob_sp_ram_arb.sv
// Two-requester round-robin arbiter in front of one iob_sp_ram.
// Each cycle at most one request is granted (combinationally, through
// a_ready/b_ready) and issued to the RAM. Reads return one cycle after the
// grant on the shared rdata bus, tagged by a single-cycle a_rvalid/b_rvalid
// pulse. Writes complete at the grant edge and produce no response.
module iob_sp_ram_arb
    import iob_sp_ram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_valid,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,

    input  logic              b_valid,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,

    output logic [DATA_W-1:0] rdata
);

    // Arbitration state: who won last, and the read awaiting its response.
    logic  r_last_grant;
    pend_t r_pend;

    // Current-cycle grant.
    logic w_grant_valid;
    logic w_grant_port;

    // RAM request mux output.
    logic              w_ram_en;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_din;
    logic [DATA_W-1:0] w_ram_dout;

    // Grant decision; nothing is granted while reset is asserted.
    // NOTE: every output gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_port  = PORT_A;
        if (!rst && (a_valid || b_valid)) begin
            w_grant_valid = 1'b1;
            w_grant_port  = rr_pick(a_valid, b_valid, r_last_grant);
        end
    end

    assign a_ready = w_grant_valid && (w_grant_port == PORT_A);
    assign b_ready = w_grant_valid && (w_grant_port == PORT_B);

    // Route the granted port's request to the RAM; idle otherwise.
    always_comb begin
        w_ram_en   = w_grant_valid;
        w_ram_we   = 1'b0;
        w_ram_addr = '0;
        w_ram_din  = '0;
        if (w_grant_valid) begin
            if (w_grant_port == PORT_A) begin
                w_ram_we   = a_we;
                w_ram_addr = a_addr;
                w_ram_din  = a_wdata;
            end else begin
                w_ram_we   = b_we;
                w_ram_addr = b_addr;
                w_ram_din  = b_wdata;
            end
        end
    end

    // Round-robin memory: remember the winner; hold when nobody was granted.
    // Reset to B so that A wins the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= PORT_B;
        end else if (w_grant_valid) begin
            r_last_grant <= w_grant_port;
        end
    end

    // Track a granted read so its data can be flagged to the right port next
    // cycle. Reset discards any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend.valid <= w_grant_valid && !w_ram_we;
            r_pend.port  <= w_grant_port;
        end
    end

    assign a_rvalid = r_pend.valid && (r_pend.port == PORT_A);
    assign b_rvalid = r_pend.valid && (r_pend.port == PORT_B);
    assign rdata    = w_ram_dout;

    iob_sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .en   (w_ram_en),
        .we   (w_ram_we),
        .addr (w_ram_addr),
        .din  (w_ram_din),
        .dout (w_ram_dout)
    );

endmodule

// File: tb/tb_iob_sp_ram_arb.sv
// Self-checking bench for iob_sp_ram_arb: directed scenarios followed by a
// randomized phase, all compared against a word-level model of the shared
// memory, the round-robin rule and the one-cycle read response.
module tb_iob_sp_ram_arb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              a_valid, a_we, a_ready, a_rvalid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              b_valid, b_we, b_ready, b_rvalid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] rdata;

    iob_sp_ram_arb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_ready  (a_ready),
        .a_rvalid (a_rvalid),
        .b_valid  (b_valid),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ready  (b_ready),
        .b_rvalid (b_rvalid),
        .rdata    (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: memory contents, which words are known, the port
    // that won most recently (0 = A, 1 = B), and the read awaiting return.
    logic [DATA_W-1:0] m_mem   [DEPTH];
    bit                m_known [DEPTH];
    bit                m_last;
    bit                m_pend_v;
    bit                m_pend_port;
    bit                m_pend_known;
    logic [DATA_W-1:0] m_pend_data;

    // Observations and model grant from the most recent step.
    logic              m_obs_ar, m_obs_br, m_obs_ra, m_obs_rb;
    logic [DATA_W-1:0] m_obs_rdata;
    bit                m_gv, m_gp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive requests, check outputs at the falling edge,
    // then advance the model across the rising edge.
    task automatic step(
        input logic              av, input logic awe,
        input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
        input logic              bv, input logic bwe,
        input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd
    );
        bit gv, gp, we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        a_valid = av; a_we = awe; a_addr = aa; a_wdata = ad;
        b_valid = bv; b_we = bwe; b_addr = ba; b_wdata = bd;

        gv = av || bv;
        if (av && bv) gp = !m_last;
        else          gp = !av;

        @(negedge clk);
        m_obs_ar = a_ready;  m_obs_br = b_ready;
        m_obs_ra = a_rvalid; m_obs_rb = b_rvalid;
        m_obs_rdata = rdata;
        check("a_ready",  32'(a_ready),  32'(gv && !gp));
        check("b_ready",  32'(b_ready),  32'(gv && gp));
        check("a_rvalid", 32'(a_rvalid), 32'(m_pend_v && !m_pend_port));
        check("b_rvalid", 32'(b_rvalid), 32'(m_pend_v && m_pend_port));
        check("rvalid_excl", 32'(a_rvalid && b_rvalid), 32'(0));
        if (m_pend_v && m_pend_known) check("rdata", rdata, m_pend_data);

        @(posedge clk);
        m_pend_v = 1'b0;
        if (gv) begin
            m_last = gp;
            we   = gp ? bwe : awe;
            addr = gp ? ba  : aa;
            data = gp ? bd  : ad;
            if (we) begin
                m_mem[addr]   = data;
                m_known[addr] = 1'b1;
            end else begin
                m_pend_v     = 1'b1;
                m_pend_port  = gp;
                m_pend_data  = m_mem[addr];
                m_pend_known = m_known[addr];
            end
        end
        m_gv = gv; m_gp = gp;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Assert reset with both ports requesting; entered and left just after
    // a rising edge. Any read in flight must vanish immediately.
    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b1; a_we = 1'b0;
        b_valid = 1'b1; b_we = 1'b0;
        #1;
        check("rst_a_ready",  32'(a_ready),  32'(0));
        check("rst_b_ready",  32'(b_ready),  32'(0));
        check("rst_a_rvalid", 32'(a_rvalid), 32'(0));
        check("rst_b_rvalid", 32'(b_rvalid), 32'(0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_a_ready",  32'(a_ready),  32'(0));
            check("rst_b_ready",  32'(b_ready),  32'(0));
            check("rst_a_rvalid", 32'(a_rvalid), 32'(0));
            check("rst_b_rvalid", 32'(b_rvalid), 32'(0));
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst = 1'b0;
        m_last   = 1'b1;
        m_pend_v = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Randomized requesters that honour the hold-until-ready rule.
    logic              ra_v, ra_we, rb_v, rb_we;
    logic [ADDR_W-1:0] ra_a, rb_a;
    logic [DATA_W-1:0] ra_d, rb_d;

    initial begin
        int cnt_a;
        int cnt_b;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        m_last = 1'b1; m_pend_v = 1'b0;
        rst = 1'b1;
        a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        @(posedge clk);
        #1;
        do_reset();
        idle();

        // Single port: write then read back on A.
        step(1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
        check("sp_wr_ready", 32'(m_obs_ar), 32'(1));
        step(1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
        check("sp_rd_ready", 32'(m_obs_ar), 32'(1));
        idle();
        check("sp_a_rvalid", 32'(m_obs_ra), 32'(1));
        check("sp_rdata",    m_obs_rdata,   32'hDEADBEEF);
        check("sp_b_rvalid", 32'(m_obs_rb), 32'(0));

        // Write with no response, then read each word back.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, ADDR_W'(16 + i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, '0, '0);
            check("wr_a_ready", 32'(m_obs_ar), 32'(1));
        end
        idle();
        check("wr_no_rvalid", 32'(m_obs_ra), 32'(0));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, ADDR_W'(16 + i), '0, 1'b0, 1'b0, '0, '0);
        idle();

        // Conflict after reset: A wins first, B next cycle.
        step(1'b1, 1'b1, 10'h001, 32'h11, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 10'h002, 32'h22, 1'b0, 1'b0, '0, '0);
        idle();
        do_reset();
        step(1'b1, 1'b0, 10'h001, '0, 1'b1, 1'b0, 10'h002, '0);
        check("cf_a_first",  32'(m_obs_ar), 32'(1));
        check("cf_b_waits",  32'(m_obs_br), 32'(0));
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h002, '0);
        check("cf_b_second", 32'(m_obs_br), 32'(1));
        check("cf_a_rvalid", 32'(m_obs_ra), 32'(1));
        check("cf_a_rdata",  m_obs_rdata,   32'h11);
        idle();
        check("cf_b_rvalid", 32'(m_obs_rb), 32'(1));
        check("cf_b_rdata",  m_obs_rdata,   32'h22);

        // Fairness: both ports always valid; B won last, so A starts.
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 10'h010, '0, 1'b1, 1'b0, 10'h011, '0);
            check("fair_seq", 32'(m_obs_ar), 32'(i % 2 == 0));
            cnt_a += int'(m_obs_ar);
            cnt_b += int'(m_obs_br);
        end
        check("fair_cnt_a", 32'(cnt_a), 32'(4));
        check("fair_cnt_b", 32'(cnt_b), 32'(4));
        idle();

        // Back-to-back: B write, A read of the same word, B read behind it.
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h3FF, 32'h55);
        step(1'b1, 1'b0, 10'h3FF, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h000, '0);
        check("b2b_b_ready",  32'(m_obs_br), 32'(1));
        check("b2b_a_rvalid", 32'(m_obs_ra), 32'(1));
        check("b2b_rdata",    m_obs_rdata,   32'h55);
        idle();
        check("b2b_b_rvalid", 32'(m_obs_rb), 32'(1));
        check("b2b_a_quiet",  32'(m_obs_ra), 32'(0));

        // Reset with a read in flight: the response must never appear.
        step(1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            check("rst_drop_a", 32'(m_obs_ra), 32'(0));
            check("rst_drop_b", 32'(m_obs_rb), 32'(0));
        end
        // RAM contents survive reset.
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h005, '0);
        idle();
        check("rst_keep_mem", m_obs_rdata, 32'hDEADBEEF);

        // Randomized traffic on a small address window to force hits.
        ra_v = 1'b0; rb_v = 1'b0;
        ra_we = 1'b0; rb_we = 1'b0; ra_a = '0; rb_a = '0; ra_d = '0; rb_d = '0;
        for (int i = 0; i < 600; i++) begin
            if (!ra_v && $urandom_range(0, 9) < 7) begin
                ra_v = 1'b1; ra_we = 1'($urandom_range(0, 1));
                ra_a = ADDR_W'($urandom_range(0, 31)); ra_d = $urandom;
            end
            if (!rb_v && $urandom_range(0, 9) < 7) begin
                rb_v = 1'b1; rb_we = 1'($urandom_range(0, 1));
                rb_a = ADDR_W'($urandom_range(0, 31)); rb_d = $urandom;
            end
            step(ra_v, ra_we, ra_a, ra_d, rb_v, rb_we, rb_a, rb_d);
            if (m_gv && !m_gp) ra_v = 1'b0;
            if (m_gv &&  m_gp) rb_v = 1'b0;
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
